// File: rtl/aes_vector_gen.sv
// aes_vector_gen: builds AES-128 key/plaintext vectors from an LFSR stream behind a valid/ready handshake.
// Optional AES_VECTOR_GEN_FIXED_KEY_EN replaces drawn keys with FIXED_KEY.
module aes_vector_gen #(
   parameter int NUM_VECTORS = 16,
   parameter int KEY_REUSE = 1,
   parameter logic [127:0] FIXED_KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         lfsr_require,
   input  logic [127:0] lfsr_data,
   output logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         vec_valid,
   input  logic         vec_ready,
   output logic [15:0]  vec_index,
   output logic         busy,
   output logic         done
);
   // one-hot encoding so every status output is a bare state flop
   typedef enum logic [3:0] {
      IDLE  = 4'b0000,
      KEY   = 4'b0001,
      PT    = 4'b0010,
      VALID = 4'b0100,
      DONE  = 4'b1000
   } state_t;
   state_t state;
   logic [7:0] reuse_cnt;
`ifdef AES_VECTOR_GEN_FIXED_KEY_EN
   assign lfsr_require = state[1];
`else
   assign lfsr_require = state[0] | state[1];
`endif
   assign vec_valid = state[2];
   assign done = state[3];
   assign busy = |state[2:0];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         key <= '0;
         plaintext <= '0;
         vec_index <= '0;
         reuse_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: if (start) begin
               state <= KEY;
               vec_index <= '0;
               reuse_cnt <= '0;
            end
            KEY: begin
`ifdef AES_VECTOR_GEN_FIXED_KEY_EN
               key <= FIXED_KEY;
`else
               key <= lfsr_data;
`endif
               state <= PT;
            end
            PT: begin
               plaintext <= lfsr_data;
               state <= VALID;
            end
            VALID: if (vec_ready) begin
               if (vec_index == 16'(NUM_VECTORS - 1)) state <= DONE;
               else begin
                  vec_index <= vec_index + 16'd1;
                  if (reuse_cnt == 8'(KEY_REUSE - 1)) begin
                     reuse_cnt <= '0;
                     state <= KEY;
                  end else begin
                     reuse_cnt <= reuse_cnt + 8'd1;
                     state <= PT;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/aes_vector_gen.md
Name: aes_vector_gen

Overview:
- Consumes the 128-bit LFSR stream and builds AES-128 test vectors (key + plaintext) for the chip under verification.
- Sits directly downstream of the LFSR in the verification platform datagenerator and drives the DUT stimulus port through a valid/ready handshake.
- Pulls LFSR values on demand via the LFSR's require input. Runs a programmed number of vectors per start, with key reuse across consecutive vectors.

Parameters:
- NUM_VECTORS, 16, vectors produced per start; legal range 1..65535.
- KEY_REUSE, 1, consecutive vectors sharing one key; legal range 1..255.
- FIXED_KEY, 128'h000102030405060708090a0b0c0d0e0f, key used only when the optional feature is enabled.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to begin a run; honoured only in IDLE or DONE.
- lfsr_require  out  1  advance request to the LFSR; the LFSR value present this cycle is consumed.
- lfsr_data  in  128  current LFSR output.
- key  out  128  vector key; registered.
- plaintext  out  128  vector plaintext; registered.
- vec_valid  out  1  key/plaintext valid to the DUT.
- vec_ready  in  1  DUT accepts the vector.
- vec_index  out  16  index of the vector currently presented, 0-based.
- busy  out  1  high in KEY, PT and VALID states.
- done  out  1  high in DONE state.

Behaviour:
- Reset (async, rst=1), effective immediately: state=IDLE; key, plaintext, vec_index and reuse_cnt all 0; vec_valid, lfsr_require, busy and done all 0.
- Draw rule: lfsr_require is Moore, decoded from state (1 in KEY and PT only). In the cycle require=1, lfsr_data is captured at the same rising edge that advances the LFSR. Each value is consumed exactly once, with no idle draw cycle.
- States:
  - IDLE: start=1 -> KEY; clear vec_index and reuse_cnt.
  - KEY: key<=lfsr_data -> PT.
  - PT: plaintext<=lfsr_data -> VALID.
  - VALID: vec_valid=1. key, plaintext and vec_index are held stable while vec_ready=0, for an unbounded number of cycles. On vec_ready=1 the handshake completes at that edge:
    - if vec_index==NUM_VECTORS-1 -> DONE (vec_index holds its value);
    - else vec_index+1, then: if reuse_cnt==KEY_REUSE-1, reuse_cnt<=0 and go to KEY; otherwise reuse_cnt+1 and go to PT.
  - DONE: done=1. Key and plaintext hold their last values. start=1 -> KEY, with the same clears as from IDLE.
- start in KEY, PT or VALID is ignored, with no side effects.
- vec_ready outside VALID is ignored.
- Minimum cycles per vector with vec_ready tied high: 3 when a new key is drawn (KEY, PT, VALID); 2 otherwise (PT, VALID).
- vec_index is 16 bits. With the legal NUM_VECTORS range it never wraps.
- reuse_cnt is 8 bits and is internal only.
- Reset asserted mid-run aborts the run with no further handshake. After release the block waits in IDLE for start.

Optional Feature:
- Macro: AES_VECTOR_GEN_FIXED_KEY_EN.
- Defined:
  - key is loaded with FIXED_KEY in the KEY state and lfsr_require is 0 in KEY, so no LFSR value is consumed for keys.
  - KEY still lasts 1 cycle, so timing is unchanged.
  - key reset value stays 0.
- Undefined: key is drawn from the LFSR as described above.

Test Plan:
- Basic draw: LFSR from reset seed 0x53504402, NUM_VECTORS=1, KEY_REUSE=1, vec_ready=1, pulse start -> key=0x...53504402, plaintext=0x...A6A08804, vec_valid high for 1 cycle with vec_index=0, then done=1; exactly 2 require cycles.
- Key reuse: NUM_VECTORS=4, KEY_REUSE=2 -> draw order K,P,P,K,P,P (6 require cycles); vec_index sequence 0,1,2,3; key changes only before vectors 0 and 2; done after the 4th handshake.
- Backpressure: hold vec_ready=0 for 5 cycles in VALID -> vec_valid stays 1; key, plaintext and vec_index are unchanged; lfsr_require=0 throughout; the 6th cycle with ready=1 advances.
- Ignored start: pulse start during PT and during VALID -> no state, counter or LFSR effect; the run completes normally.
- Async reset: assert rst mid-VALID (between clock edges) -> vec_valid, key and plaintext go to 0 immediately; after release the block stays in IDLE until start.
- Fixed-key build (AES_VECTOR_GEN_FIXED_KEY_EN): NUM_VECTORS=2, KEY_REUSE=1 -> key=FIXED_KEY for both vectors; plaintexts are 0x...53504402 then 0x...A6A08804; 2 require cycles total.
